flex_ff_bank: RTL
=================

Name: flex_ff_bank

Overview:
Parametrised bank of WIDTH flip-flops sharing one clock. It is the generalised successor of the single-bit SR flip-flop. A run-time mode input selects D, T, JK or SR behaviour for all bits. The bank adds clock enable, synchronous parallel load, complementary outputs, and illegal-SR detection with a sticky flag and a saturating event counter. It serves as the lab's general-purpose storage/toggle element for register, counter and control exercises.

Parameters:
WIDTH, 8, number of flip-flop bits (1..32)
RST_VAL, 0, WIDTH-bit value loaded into Q on reset
ERR_CNT_W, 4, width of the illegal-event counter

Ports:
CLK  input  1  clock; all state updates on rising edge
rst_in  input  1  asynchronous, active-high reset
mode_in  input  2  00=D, 01=T, 10=JK, 11=SR
en_in  input  1  clock enable for the flip-flop update
A_in  input  WIDTH  D / T / J / S per bit, depending on mode
B_in  input  WIDTH  K / R per bit; ignored in D and T modes
ld_in  input  1  synchronous parallel load
ld_val_in  input  WIDTH  load value
err_clr_in  input  1  clears err_out and err_cnt_out
Q_out  output  WIDTH  flip-flop state
Qn_out  output  WIDTH  bitwise complement of Q_out, always
err_out  output  1  sticky illegal-SR flag
err_cnt_out  output  ERR_CNT_W  count of illegal cycles, saturating

Behaviour:
- Reset: rst_in high forces Q_out=RST_VAL, err_out=0, err_cnt_out=0 immediately, with no wait for CLK. State holds while rst_in is high. Deassertion mid-sequence resumes at the next rising edge with no lost or extra edge behaviour.
- Qn_out equals ~Q_out combinationally at all times, including during reset.
- Priority each rising edge: ld_in > en_in. If ld_in=1, Q<=ld_val_in regardless of en_in and mode_in, and no illegal detection is done that cycle.
- If ld_in=0 and en_in=0, Q holds.
- If ld_in=0 and en_in=1, each bit i updates per mode (sampled on the same edge; no pipeline):
  - D (00): Q[i]<=A[i]
  - T (01): Q[i]<=Q[i]^A[i]
  - JK (10): 00 hold, 01 reset to 0, 10 set to 1, 11 toggle (A=J, B=K)
  - SR (11): 00 hold, 01 reset to 0, 10 set to 1, 11 illegal. An illegal bit holds its previous value; other bits update normally.
- Latency: one edge from inputs to Q_out. Mode change takes effect on the same edge where the new mode is sampled.
- Illegal event: a cycle with ld_in=0, en_in=1, mode_in=11 and any bit having A[i]&B[i]=1. It counts once per cycle regardless of how many bits are illegal.
- On an illegal event: err_out<=1 (sticky), err_cnt_out increments by 1 and saturates at 2^ERR_CNT_W-1 with no wrap.
- err_clr_in=1 without an illegal event that cycle: err_out<=0, err_cnt_out<=0.
- err_clr_in=1 with an illegal event the same cycle: the clear applies first, then the event, giving err_out=1 and err_cnt_out=1.
- err_clr_in does not affect Q_out.
- WIDTH=1 must behave identically to a single SR/JK/D/T flip-flop with reset.

Test Plan:
- Reset mid-run: Q_out=8'hA5, assert rst_in between edges -> Q_out=8'h00 and Qn_out=8'hFF before the next edge. Release -> next edge in D mode with A_in=8'h3C gives Q_out=8'h3C.
- Mode sweep from Q=8'h0F, en_in=1: T with A_in=8'hFF -> 8'hF0. JK with A=8'hC0, B=8'h30 -> 8'hC0. D with A=8'h12 -> 8'h12.
- SR illegal: Q=8'h0F, mode 11, A_in=8'h81, B_in=8'h01 -> Q_out=8'h8F (bit0 held, bit7 set), err_out=1, err_cnt_out=1. Repeat for 20 cycles -> err_cnt_out saturates at 15.
- Clear and event collide: err_cnt_out=5, err_clr_in=1 with an illegal SR input on the same edge -> err_out=1, err_cnt_out=1. Next edge, clear only -> err_out=0, err_cnt_out=0.
- Priority: ld_in=1, en_in=0, ld_val_in=8'h5A, mode 11, A=B=8'hFF -> Q_out=8'h5A, no error. ld_in=0, en_in=0 -> Q holds at 8'h5A.
- WIDTH=1 JK toggle: J=K=1 for 4 edges from reset -> Q_out sequence 1,0,1,0.

Source files
------------

// File: rtl/flex_ff_bank.sv
// ---------------------------------------------------------------------------
// flex_ff_bank
// Bank of WIDTH flip-flops sharing one clock. A run-time mode selects D, T,
// JK or SR behaviour for every bit. The bank has a clock enable, a
// synchronous parallel load, complementary outputs, and detection of the
// illegal SR input combination. Detection feeds a sticky flag and a
// saturating event counter.
//
// Ports:
//   CLK          clock; all state updates on the rising edge
//   rst_in       asynchronous active-high reset (Q=RST_VAL, error state cleared)
//   mode_in      00=D, 01=T, 10=JK, 11=SR
//   en_in        clock enable for the flip-flop update
//   A_in         D / T / J / S per bit
//   B_in         K / R per bit (unused in D and T modes)
//   ld_in        synchronous parallel load; has priority over en_in
//   ld_val_in    parallel load value
//   err_clr_in   clears err_out and err_cnt_out
//   Q_out        flip-flop state
//   Qn_out       bitwise complement of Q_out
//   err_out      sticky illegal-SR flag
//   err_cnt_out  saturating count of cycles with an illegal SR input
// ---------------------------------------------------------------------------
module flex_ff_bank #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RST_VAL   = '0,
   parameter int               ERR_CNT_W = 4
) (
   input  logic                 CLK,
   input  logic                 rst_in,
   input  logic [1:0]           mode_in,
   input  logic                 en_in,
   input  logic [WIDTH-1:0]     A_in,
   input  logic [WIDTH-1:0]     B_in,
   input  logic                 ld_in,
   input  logic [WIDTH-1:0]     ld_val_in,
   input  logic                 err_clr_in,
   output logic [WIDTH-1:0]     Q_out,
   output logic [WIDTH-1:0]     Qn_out,
   output logic                 err_out,
   output logic [ERR_CNT_W-1:0] err_cnt_out
);

   localparam logic [1:0] MODE_D  = 2'b00;
   localparam logic [1:0] MODE_T  = 2'b01;
   localparam logic [1:0] MODE_JK = 2'b10;
   localparam logic [1:0] MODE_SR = 2'b11;

   localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
   localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

   logic [WIDTH-1:0] q_nxt;
   logic             illegal_evt;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] cnt);
      if (cnt == CNT_MAX) begin
         sat_inc = cnt;
      end else begin
         sat_inc = cnt + CNT_ONE;
      end
   endfunction

   // A load suppresses detection, so only an enabled SR update can be illegal.
   assign illegal_evt = !ld_in && en_in && (mode_in == MODE_SR) && (|(A_in & B_in));

   always_comb begin
      q_nxt = Q_out;
      if (ld_in) begin
         q_nxt = ld_val_in;
      end else if (en_in) begin
         case (mode_in)
            MODE_D:  q_nxt = A_in;
            MODE_T:  q_nxt = Q_out ^ A_in;
            // Characteristic equation Q+ = J&~Q | ~K&Q.
            MODE_JK: q_nxt = (A_in & ~Q_out) | (~B_in & Q_out);
            // Set where S&~R, reset where ~S&R. Where S==R the bit holds,
            // which covers both the hold case and the illegal case.
            MODE_SR: q_nxt = (Q_out & ~(A_in ^ B_in)) | (A_in & ~B_in);
            default: q_nxt = Q_out;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge rst_in) begin
      if (rst_in) begin
         Q_out <= RST_VAL;
      end else begin
         Q_out <= q_nxt;
      end
   end

   // The clear is applied before the event, so a collision leaves a count of one.
   always_ff @(posedge CLK or posedge rst_in) begin
      if (rst_in) begin
         err_out     <= 1'b0;
         err_cnt_out <= '0;
      end else if (illegal_evt) begin
         err_out     <= 1'b1;
         err_cnt_out <= err_clr_in ? CNT_ONE : sat_inc(err_cnt_out);
      end else if (err_clr_in) begin
         err_out     <= 1'b0;
         err_cnt_out <= '0;
      end
   end

   assign Qn_out = ~Q_out;

endmodule
